// File: rtl/ram_16_pkg.sv
// Shared constants for the 16x16 register-file RAM.
package ram_16_pkg;
    localparam int RAM_WIDTH = 16;
    localparam int RAM_DEPTH = 16;
    localparam int RAM_AW    = 4;
endpackage

// File: rtl/ram_16_register16.sv
// One storage word: load-enabled register with async active-low clear.
import ram_16_pkg::*;

module register16 #(
    parameter int WIDTH = RAM_WIDTH
) (
    output logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    input  logic             clk,
    input  logic             rst_n
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ram_16.sv
// Word-addressed RAM built from DEPTH registers, one-hot write decode,
// combinational read mux.
import ram_16_pkg::*;

module ram_16 #(
    parameter int WIDTH = RAM_WIDTH,
    parameter int DEPTH = RAM_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] in,
    input  logic [AW-1:0]    addr,
    input  logic             write,
    input  logic             clk,
    input  logic             rst_n
);

    logic [DEPTH-1:0] sel;
    logic [WIDTH-1:0] words [DEPTH];

    // An unknown write enable falls through the if and decodes as no write.
    always_comb begin
        sel = '0;
        if (write) begin
            sel[addr] = 1'b1;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        register16 #(
            .WIDTH(WIDTH)
        ) u_word (
            .q    (words[i]),
            .d    (in),
            .load (sel[i]),
            .clk  (clk),
            .rst_n(rst_n)
        );
    end

    assign out = words[addr];

endmodule

// File: tb/tb_ram_16.sv
// Randomized self-checking bench for ram_16 against an array model.
module tb_ram_16;

    logic [15:0] out;
    logic [15:0] in;
    logic [3:0]  addr;
    logic        write;
    logic        clk;
    logic        rst_n;

    logic [15:0] mem [16];
    logic [15:0] vals [8];
    int          passed;
    int          total;

    ram_16 dut (
        .out  (out),
        .in   (in),
        .addr (addr),
        .write(write),
        .clk  (clk),
        .rst_n(rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model commits the pending write at the edge, then settles 1 unit.
    task automatic tick();
        if (write === 1'b1 && rst_n === 1'b1) mem[addr] = in;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) mem[i] = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        write = 1'b0;
        in    = '0;
        clear_model();
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            #1;
            total++;
            if (out !== 16'h0000)
                $display("FAIL reset addr=%0d got=%h exp=0000", a, out);
            else passed++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read_no_write();
        for (int a = 0; a < 16; a++) begin
            write = 1'b0;
            addr  = 4'(a);
            in    = (a == 0) ? 16'h0070 : 16'($urandom_range(1, 16'hffff));
            tick();
            total++;
            if (out !== mem[a])
                $display("FAIL no_write addr=%0d got=%h exp=%h", a, out, mem[a]);
            else passed++;
        end
    endtask

    task automatic test_write_readback();
        for (int a = 0; a < 8; a++) begin
            write = 1'b1;
            addr  = 4'(a);
            in    = vals[a];
            tick();
            total++;
            if (out !== vals[a])
                $display("FAIL wr addr=%0d got=%h exp=%h", a, out, vals[a]);
            else passed++;
        end
        write = 1'b0;
        in    = '0;
        for (int a = 0; a < 8; a++) begin
            addr = 4'(a);
            #1;
            total++;
            if (out !== vals[a])
                $display("FAIL rb addr=%0d got=%h exp=%h", a, out, vals[a]);
            else passed++;
        end
    endtask

    task automatic test_upper_half();
        write = 1'b0;
        for (int a = 8; a < 16; a++) begin
            addr = 4'(a);
            #1;
            total++;
            if (out !== 16'h0000)
                $display("FAIL upper_zero addr=%0d got=%h exp=0000", a, out);
            else passed++;
        end
        for (int a = 8; a < 16; a++) begin
            write = 1'b1;
            addr  = 4'(a);
            in    = vals[a-8];
            tick();
            total++;
            if (out !== vals[a-8])
                $display("FAIL upper_wr addr=%0d got=%h exp=%h", a, out, vals[a-8]);
            else passed++;
        end
        write = 1'b0;
        for (int a = 0; a < 8; a++) begin
            addr = 4'(a);
            #1;
            total++;
            if (out !== vals[a])
                $display("FAIL lower_hold addr=%0d got=%h exp=%h", a, out, vals[a]);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        for (int a = 0; a < 16; a++) begin
            write = 1'b1;
            addr  = 4'(a);
            in    = 16'($urandom_range(1, 16'hffff));
            tick();
        end
        // Arm a write, then drop reset before its edge arrives.
        write = 1'b1;
        addr  = 4'd6;
        in    = 16'h1234;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        clear_model();
        #1;
        total++;
        if (out !== 16'h0000)
            $display("FAIL async_now addr=6 got=%h exp=0000", out);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (out !== 16'h0000)
            $display("FAIL wr_in_reset addr=6 got=%h exp=0000", out);
        else passed++;
        write = 1'b0;
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            #1;
            total++;
            if (out !== 16'h0000)
                $display("FAIL async_sweep addr=%0d got=%h exp=0000", a, out);
            else passed++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        write = 1'b1;
        addr  = 4'd9;
        in    = 16'hA5C3;
        #1;
        total++;
        if (out !== 16'h0000)
            $display("FAIL post_rst_pre addr=9 got=%h exp=0000", out);
        else passed++;
        tick();
        total++;
        if (out !== 16'hA5C3)
            $display("FAIL post_rst_wr addr=9 got=%h exp=a5c3", out);
        else passed++;
    endtask

    task automatic test_same_edge();
        logic [15:0] old;
        write = 1'b1;
        addr  = 4'd3;
        in    = 16'hBEEF;
        old   = mem[3];
        #1;
        total++;
        if (out !== old)
            $display("FAIL same_edge_pre got=%h exp=%h", out, old);
        else passed++;
        tick();
        total++;
        if (out !== 16'hBEEF)
            $display("FAIL same_edge_post got=%h exp=beef", out);
        else passed++;
        write = 1'b0;
        addr  = 4'd9;
        #1;
        total++;
        if (out !== mem[9])
            $display("FAIL addr_follow got=%h exp=%h", out, mem[9]);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] a;
        for (int n = 0; n < 300; n++) begin
            a     = 4'($urandom_range(0, 15));
            write = ($urandom_range(0, 2) != 0);
            addr  = a;
            in    = (n % 17 == 0) ? mem[a] : 16'($urandom);
            #1;
            total++;
            if (out !== mem[a])
                $display("FAIL rnd_pre n=%0d addr=%0d got=%h exp=%h", n, a, out, mem[a]);
            else passed++;
            tick();
            total++;
            if (out !== mem[a])
                $display("FAIL rnd_post n=%0d addr=%0d got=%h exp=%h", n, a, out, mem[a]);
            else passed++;
        end
        write = 1'b0;
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i);
            #1;
            total++;
            if (out !== mem[i])
                $display("FAIL rnd_final addr=%0d got=%h exp=%h", i, out, mem[i]);
            else passed++;
        end
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        vals[0] = 16'h0070;
        vals[1] = 16'h0065;
        vals[2] = 16'h0063;
        vals[3] = 16'h0075;
        vals[4] = 16'h006C;
        vals[5] = 16'h0069;
        vals[6] = 16'h0061;
        vals[7] = 16'h0072;
        addr    = '0;
        test_reset();
        test_read_no_write();
        test_write_readback();
        test_upper_half();
        test_async_reset();
        test_same_edge();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
